// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the PLL lock controller.
// Build option: LOCK_SYNC_EN (see pll_lock_ctrl.sv).
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_e;

    localparam int unsigned DEF_RST_CYCLES   = 16;
    localparam int unsigned DEF_LOCK_STABLE  = 64;
    localparam int unsigned DEF_LOCK_TIMEOUT = 1024;
    localparam int unsigned DEF_MAX_RETRY    = 3;
    localparam int unsigned DEF_CNT_W        = 11;
    localparam int unsigned DEF_RTRY_W       = 2;

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// PLL reset/lock and downstream enable signals between the controller and its
// environment. master = controller side, slave = PLL/downstream side.
interface pll_lock_ctrl_if
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RTRY_W = DEF_RTRY_W
);
    logic              pll_lock;
    logic              en_req;
    logic              restart;
    logic              pll_rst;
    logic              ready;
    logic              clk_en;
    logic              lost_lock;
    logic [RTRY_W-1:0] retry_cnt;
    logic              fail;

    modport master (
        input  pll_lock, en_req, restart,
        output pll_rst, ready, clk_en, lost_lock, retry_cnt, fail
    );

    modport slave (
        output pll_lock, en_req, restart,
        input  pll_rst, ready, clk_en, lost_lock, retry_cnt, fail
    );
endinterface

// File: rtl/lock_sync.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    // Shift the raw lock through two stages; cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock controller: sequences the PLL out of reset, qualifies lock
// stability, grants a registered clock enable, and retries on timeout or lock
// loss until the retry budget is spent.
// Build option: define LOCK_SYNC_EN to pass pll_lock through a 2-flop
// synchroniser (adds 2 cycles to every lock response).
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned RTRY_W       = DEF_RTRY_W
) (
    input logic             clk,
    input logic             rst,
    pll_lock_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0]  RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTRY_W-1:0] RETRY_MAX    = RTRY_W'(MAX_RETRY);

    logic lock_q;

`ifdef LOCK_SYNC_EN
    lock_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.pll_lock),
        .q_o (lock_q)
    );
`else
    // Lock is assumed to be generated in the clk domain.
    assign lock_q = bus.pll_lock;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTRY_W-1:0] retry_q, retry_d;
    logic              pll_rst_q, pll_rst_d;
    logic              ready_q, ready_d;
    logic              clk_en_q, clk_en_d;
    logic              lost_q, lost_d;
    logic              fail_q, fail_d;
    logic              retry_evt;

    // Next state, shared counter, retry accounting and registered-output values.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retry_d   = retry_q;
        lost_d    = 1'b0;
        retry_evt = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_evt = 1'b1;
                end
            end
            ST_STABLE: begin
                // A lock glitch restarts qualification without charging a retry.
                if (!lock_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_q) begin
                    lost_d    = 1'b1;
                    retry_evt = 1'b1;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase

        // Retry re-initialises the PLL; retry_cnt saturates at MAX_RETRY.
        if (retry_evt) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_RESET;
            end else begin
                state_d = ST_FAIL;
            end
        end

        // restart overrides lock and timeout events.
        if (bus.restart) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b0;
        end

        pll_rst_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
        ready_d   = (state_d == ST_RUN);
        clk_en_d  = (state_d == ST_RUN) && bus.en_req && lock_q;
        fail_d    = (state_d == ST_FAIL);
    end

    // State and output registers with synchronous reset to the idle values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update from the same pre-edge values.
        if (rst) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            clk_en_q  <= 1'b0;
            lost_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            clk_en_q  <= clk_en_d;
            lost_q    <= lost_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.ready     = ready_q;
    assign bus.clk_en    = clk_en_q;
    assign bus.lost_lock = lost_q;
    assign bus.retry_cnt = retry_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl (default parameters, LOCK_SYNC_EN undefined).
// Each test pushes expected output vectors tagged with an absolute cycle number;
// a negedge monitor pops and compares them as the DUT reaches those cycles.
module tb_pll_lock_ctrl;

    typedef struct {
        string      tag;
        int         cyc;
        logic [6:0] exp;
        logic [6:0] mask;
    } exp_t;

    // Output vector layout: {fail, retry_cnt[1:0], lost_lock, clk_en, ready, pll_rst}
    localparam logic [6:0] ALL    = 7'b1111111;
    localparam logic [6:0] M_PRST = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;
    exp_t sb[$];
    exp_t mon_e;

    pll_lock_ctrl_if #(.RTRY_W(2)) bus_if ();

    pll_lock_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] obs;
    assign obs = {bus_if.fail, bus_if.retry_cnt, bus_if.lost_lock,
                  bus_if.clk_en, bus_if.ready, bus_if.pll_rst};

    // Scoreboard monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks = checks + 1;
            if (mon_e.cyc != cyc) begin
                failures = failures + 1;
                $display("FAIL %s: expectation for cycle %0d reached at cycle %0d",
                         mon_e.tag, mon_e.cyc, cyc);
            end else if ((obs & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                failures = failures + 1;
                $display("FAIL %s: cyc=%0d got={fail,rtry,lost,cen,rdy,prst}=%b want=%b mask=%b",
                         mon_e.tag, cyc, obs, mon_e.exp, mon_e.mask);
            end
        end
    end

    function automatic logic [6:0] mk(input logic f, input logic [1:0] r, input logic l,
                                      input logic ce, input logic rd, input logic pr);
        return {f, r, l, ce, rd, pr};
    endfunction

    task automatic expect_at(input string tag, input int c, input logic [6:0] e,
                             input logic [6:0] m);
        exp_t x;
        x = '{tag, c, e, m};
        sb.push_back(x);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Apply rst for three edges; c0 is the cycle at which rst is released, so
    // edge k after release is observed at cycle c0+k.
    task automatic do_reset(output int c0);
        int n;
        @(negedge clk);
        rst = 1'b1;
        bus_if.restart = 1'b0;
        n = cyc;
        expect_at("reset_vals", n + 2, mk(0, 0, 0, 0, 0, 1), ALL);
        wait_until(n + 3);
        rst = 1'b0;
        c0 = n + 3;
    endtask

    task automatic test_reset_lock();
        int c0;
        bus_if.pll_lock = 1'b1;
        bus_if.en_req   = 1'b0;
        do_reset(c0);
        expect_at("prst_first",   c0 + 1,  mk(0, 0, 0, 0, 0, 1), ALL);
        expect_at("prst_last",    c0 + 15, mk(0, 0, 0, 0, 0, 1), ALL);
        expect_at("prst_release", c0 + 16, mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("ready_before", c0 + 80, mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("ready_rise",   c0 + 81, mk(0, 0, 0, 0, 1, 0), ALL);
        expect_at("cen_pre",      c0 + 85, mk(0, 0, 0, 0, 1, 0), ALL);
        expect_at("cen_rise",     c0 + 86, mk(0, 0, 0, 1, 1, 0), ALL);
        expect_at("cen_hold",     c0 + 90, mk(0, 0, 0, 1, 1, 0), ALL);
        expect_at("cen_fall",     c0 + 91, mk(0, 0, 0, 0, 1, 0), ALL);
        wait_until(c0 + 85);
        bus_if.en_req = 1'b1;
        wait_until(c0 + 90);
        bus_if.en_req = 1'b0;
        wait_until(c0 + 92);
    endtask

    task automatic test_stable_glitch();
        int c0;
        bus_if.pll_lock = 1'b1;
        bus_if.en_req   = 1'b0;
        do_reset(c0);
        expect_at("glitch_pre",     c0 + 46,  mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("glitch_edge",    c0 + 47,  mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("glitch_nominal", c0 + 81,  mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("glitch_late_pre",c0 + 111, mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("glitch_ready",   c0 + 112, mk(0, 0, 0, 0, 1, 0), ALL);
        wait_until(c0 + 46);
        bus_if.pll_lock = 1'b0;
        wait_until(c0 + 47);
        bus_if.pll_lock = 1'b1;
        wait_until(c0 + 113);
    endtask

    task automatic test_lost_lock();
        int c0;
        bus_if.pll_lock = 1'b1;
        bus_if.en_req   = 1'b1;
        do_reset(c0);
        expect_at("run_entry",      c0 + 81,  mk(0, 0, 0, 1, 1, 0), ALL);
        expect_at("run_steady",     c0 + 100, mk(0, 0, 0, 1, 1, 0), ALL);
        expect_at("lost_pulse",     c0 + 101, mk(0, 1, 1, 0, 0, 0), ALL & ~M_PRST);
        expect_at("lost_after",     c0 + 102, mk(0, 1, 0, 0, 0, 1), ALL);
        expect_at("retry_prst_end", c0 + 116, mk(0, 1, 0, 0, 0, 1), ALL);
        expect_at("retry_prst_off", c0 + 117, mk(0, 1, 0, 0, 0, 0), ALL);
        expect_at("rerun_pre",      c0 + 181, mk(0, 1, 0, 0, 0, 0), ALL);
        expect_at("rerun",          c0 + 182, mk(0, 1, 0, 1, 1, 0), ALL);
        expect_at("run_restart",    c0 + 191, mk(0, 0, 0, 0, 0, 1), ALL);
        wait_until(c0 + 100);
        bus_if.pll_lock = 1'b0;
        wait_until(c0 + 101);
        bus_if.pll_lock = 1'b1;
        wait_until(c0 + 190);
        bus_if.restart = 1'b1;
        wait_until(c0 + 191);
        bus_if.restart = 1'b0;
        wait_until(c0 + 192);
    endtask

    task automatic test_timeout_fail();
        int c0;
        bus_if.pll_lock = 1'b0;
        bus_if.en_req   = 1'b1;
        do_reset(c0);
        t0 = c0;
        expect_at("to_wait",     c0 + 16,   mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("to1_pre",     c0 + 1039, mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("to1",         c0 + 1040, mk(0, 1, 0, 0, 0, 1), ALL);
        expect_at("to1_prst_end",c0 + 1055, mk(0, 1, 0, 0, 0, 1), ALL);
        expect_at("to1_prst_off",c0 + 1056, mk(0, 1, 0, 0, 0, 0), ALL);
        expect_at("to2_pre",     c0 + 2079, mk(0, 1, 0, 0, 0, 0), ALL);
        expect_at("to2",         c0 + 2080, mk(0, 2, 0, 0, 0, 1), ALL);
        expect_at("to3",         c0 + 3120, mk(0, 3, 0, 0, 0, 1), ALL);
        expect_at("to4_pre",     c0 + 4159, mk(0, 3, 0, 0, 0, 0), ALL);
        expect_at("fail_enter",  c0 + 4160, mk(1, 3, 0, 0, 0, 1), ALL);
        expect_at("fail_sticky", c0 + 4300, mk(1, 3, 0, 0, 0, 1), ALL);
        wait_until(c0 + 4301);
    endtask

    task automatic test_restart();
        int c0;
        c0 = t0;
        expect_at("restart_clear",   c0 + 4311, mk(0, 0, 0, 0, 0, 1), ALL);
        expect_at("restart_prst_end",c0 + 4326, mk(0, 0, 0, 0, 0, 1), ALL);
        expect_at("restart_prst_off",c0 + 4327, mk(0, 0, 0, 0, 0, 0), ALL);
        expect_at("rst_restart",     c0 + 4331, mk(0, 0, 0, 0, 0, 1), ALL);
        expect_at("rst_prst_end",    c0 + 4346, mk(0, 0, 0, 0, 0, 1), ALL);
        expect_at("rst_prst_off",    c0 + 4347, mk(0, 0, 0, 0, 0, 0), ALL);
        wait_until(c0 + 4310);
        bus_if.restart = 1'b1;
        wait_until(c0 + 4311);
        bus_if.restart = 1'b0;
        wait_until(c0 + 4330);
        bus_if.restart = 1'b1;
        rst = 1'b1;
        wait_until(c0 + 4331);
        bus_if.restart = 1'b0;
        rst = 1'b0;
        wait_until(c0 + 4348);
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.restart  = 1'b0;
        bus_if.pll_lock = 1'b0;
        bus_if.en_req   = 1'b0;
        test_reset_lock();
        test_stable_glitch();
        test_lost_lock();
        test_timeout_fail();
        test_restart();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
